// File: rtl/dehaze_tx_ctrl.sv
// Per-pixel transmission sequencer: scale dark channel, capture t, run reciprocal, hand off t and 1/t.
// Optional per-frame minimum-t statistic enabled by TX_STATS_EN.
module dehaze_tx_ctrl #(
  parameter logic [15:0] OMEGA        = 16'd62259,
  parameter int          TIMEOUT      = 64,
  parameter int          FRAME_PIXELS = 307200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_dark,
  output logic [15:0] sub_a,
  input  logic [15:0] sub_diff,
  output logic        recip_start,
  output logic        recip_abort,
  output logic [15:0] recip_operand,
  input  logic        recip_done,
  input  logic [15:0] recip_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_t,
  output logic [15:0] out_inv_t,
  output logic        err_timeout,
`ifdef TX_STATS_EN
  output logic [15:0] t_min,
`endif
  output logic        frame_done
);

  // state | meaning
  // IDLE  | accepting a pixel, in_ready high
  // SUB   | scaled dark on sub_a, capture t from subtractor
  // START | recip_start pulse, timeout counter cleared
  // WAIT  | waiting for recip_done or timeout
  // OUT   | presenting t and 1/t until out_ready
  typedef enum logic [2:0] {S_IDLE, S_SUB, S_START, S_WAIT, S_OUT} state_t;

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int PW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 2);
  localparam logic [PW-1:0] PIX_LAST = PW'(FRAME_PIXELS - 1);

  state_t        r_state;
  logic [15:0]   r_scaled;
  logic [15:0]   r_t;
  logic [15:0]   r_inv;
  logic [TW-1:0] r_tcnt;
  logic [PW-1:0] r_pix;
  logic          r_in_ready;
  logic          r_start;
  logic          r_abort;
  logic          r_out_valid;
  logic          r_err;

  logic [15:0]   w_scaled;
  logic          w_hs;
  logic          w_last;

  assign w_scaled = 16'((32'(in_dark) * 32'(OMEGA)) >> 16);
  assign w_hs     = r_out_valid & out_ready;
  assign w_last   = (r_pix == PIX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_scaled    <= '0;
      r_t         <= '0;
      r_inv       <= '0;
      r_tcnt      <= '0;
      r_pix       <= '0;
      r_in_ready  <= 1'b0;
      r_start     <= 1'b0;
      r_abort     <= 1'b0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_in_ready && in_valid) begin
            r_scaled   <= w_scaled;
            r_in_ready <= 1'b0;
            r_state    <= S_SUB;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_SUB: begin
          r_t     <= sub_diff;
          r_start <= 1'b1;
          r_state <= S_START;
        end
        S_START: begin
          r_tcnt  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_tcnt <= r_tcnt + 1'b1;
          // done takes priority over a coincident timeout
          if (recip_done) begin
            r_inv       <= recip_result;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end else if (r_tcnt == TO_LAST) begin
            r_inv       <= 16'hFFFF;
            r_abort     <= 1'b1;
            r_err       <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_pix       <= w_last ? '0 : r_pix + 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign sub_a         = r_scaled;
  assign recip_start   = r_start;
  assign recip_abort   = r_abort;
  assign recip_operand = r_t;
  assign out_valid     = r_out_valid;
  assign out_t         = r_t;
  assign out_inv_t     = r_inv;
  assign err_timeout   = r_err;
  assign frame_done    = w_hs & w_last;

`ifdef TX_STATS_EN
  logic [15:0] r_run_min;
  logic [15:0] r_t_min;
  logic [15:0] w_min_next;

  assign w_min_next = (r_t < r_run_min) ? r_t : r_run_min;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_min <= 16'hFFFF;
      r_t_min   <= 16'hFFFF;
    end else if (w_hs) begin
      if (w_last) begin
        r_t_min   <= w_min_next;
        r_run_min <= 16'hFFFF;
      end else begin
        r_run_min <= w_min_next;
      end
    end
  end

  assign t_min = r_t_min;
`endif

endmodule

// File: tb/tb_dehaze_tx_ctrl.sv
// Self-checking bench for dehaze_tx_ctrl: directed corner cases plus randomized pixels
// against an arithmetic model of scaling, subtraction, reciprocal, timeout and framing.
module tb_dehaze_tx_ctrl;
  localparam int TO = 32;
  localparam int FP = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_dark;
  logic [15:0] sub_a;
  logic [15:0] sub_diff;
  logic        recip_start;
  logic        recip_abort;
  logic [15:0] recip_operand;
  logic        recip_done;
  logic [15:0] recip_result;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_t;
  logic [15:0] out_inv_t;
  logic        err_timeout;
  logic        frame_done;
`ifdef TX_STATS_EN
  logic [15:0] t_min;
`endif

  int          n_assert = 0;
  int          n_fail   = 0;
  int          pix_cnt  = 0;
  bit          err_exp  = 1'b0;
  logic [15:0] run_min  = 16'hFFFF;
  logic [15:0] tmin_exp = 16'hFFFF;

  dehaze_tx_ctrl #(.OMEGA(16'd62259), .TIMEOUT(TO), .FRAME_PIXELS(FP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_dark(in_dark),
    .sub_a(sub_a), .sub_diff(sub_diff),
    .recip_start(recip_start), .recip_abort(recip_abort), .recip_operand(recip_operand),
    .recip_done(recip_done), .recip_result(recip_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_t(out_t), .out_inv_t(out_inv_t),
    .err_timeout(err_timeout),
`ifdef TX_STATS_EN
    .t_min(t_min),
`endif
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] f_scale(input logic [15:0] d);
    longint p;
    p = longint'(d) * 62259;
    return 16'(p / 65536);
  endfunction

  // t = 1 - x in Q0.16, saturated at 0xFFFF, clamped below at 0.25
  function automatic logic [15:0] f_t(input logic [15:0] x);
    longint v;
    v = 65536 - longint'(x);
    if (v > 65535) v = 65535;
    if (v < 16384) v = 16384;
    return 16'(v);
  endfunction

  function automatic logic [15:0] f_inv(input logic [15:0] t);
    longint v;
    v = (longint'(1) << 30) / longint'(t);
    if (v > 65535) v = 65535;
    return 16'(v);
  endfunction

  always_comb sub_diff = f_t(sub_a);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // lat: cycles after the start pulse that done is driven (0 = never); bp: cycles of backpressure
  task automatic do_pixel(input logic [15:0] dark, input int lat, input int bp, input bit late_done);
    logic [15:0] es, et, ei;
    bit          to, seen;
    int          kout;
    es = f_scale(dark);
    et = f_t(es);
    to = (lat == 0) || (lat >= TO);
    ei = to ? 16'hFFFF : f_inv(et);
    @(negedge clk);
    recip_done = 1'b0;
    chk("idle_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_dark  = dark;
    @(negedge clk);
    in_valid = 1'b0;
    in_dark  = 16'($urandom);
    chk("sub_a", sub_a, es);
    chk("sub_in_ready", in_ready, 0);
    @(negedge clk);
    chk("recip_start", recip_start, 1);
    chk("recip_operand", recip_operand, et);
    chk("start_out_valid", out_valid, 0);
    seen = 1'b0;
    kout = 0;
    for (int i = 1; i <= TO + 5; i++) begin
      @(negedge clk);
      recip_done   = 1'b0;
      recip_result = 16'($urandom);
      if (out_valid) begin
        seen = 1'b1;
        kout = i;
        break;
      end
      chk("wait_start_low", recip_start, 0);
      chk("wait_abort_low", recip_abort, 0);
      if (i == lat) begin
        recip_done   = 1'b1;
        recip_result = f_inv(et);
      end
    end
    chk("out_valid_seen", seen, 1);
    chk("latency_from_start", kout, to ? TO : lat + 1);
    chk("abort_pulse", recip_abort, to);
    chk("out_t", out_t, et);
    chk("out_inv_t", out_inv_t, ei);
    err_exp = err_exp | to;
    chk("err_timeout", err_timeout, err_exp);
    for (int i = 0; i < bp; i++) begin
      out_ready = 1'b0;
      if (late_done && i == 0) begin
        recip_done   = 1'b1;
        recip_result = 16'h1234;
      end
      @(negedge clk);
      recip_done = 1'b0;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_t", out_t, et);
      chk("bp_out_inv_t", out_inv_t, ei);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_abort_low", recip_abort, 0);
      chk("bp_frame_done", frame_done, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("frame_done", frame_done, (pix_cnt == FP - 1));
    if (pix_cnt == FP - 1) begin
      tmin_exp = (et < run_min) ? et : run_min;
      run_min  = 16'hFFFF;
      pix_cnt  = 0;
    end else begin
      run_min  = (et < run_min) ? et : run_min;
      pix_cnt++;
    end
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_frame_done", frame_done, 0);
    chk("post_err_timeout", err_timeout, err_exp);
`ifdef TX_STATS_EN
    chk("t_min", t_min, tmin_exp);
`endif
    if (late_done) begin
      recip_done   = 1'b1;
      recip_result = 16'h5678;
    end
  endtask

  initial begin
    int lat;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_dark      = '0;
    recip_done   = 1'b0;
    recip_result = '0;
    out_ready    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_recip_start", recip_start, 0);
    chk("rst_sub_a", sub_a, 0);
    chk("rst_err", err_timeout, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
`ifdef TX_STATS_EN
    chk("rst_t_min", t_min, 16'hFFFF);
`endif

    do_pixel(16'h0000, 1, 0, 1'b0);
    do_pixel(16'hFFFF, 3, 2, 1'b0);
    do_pixel(16'h8000, TO - 1, 0, 1'b0);
    do_pixel(16'h1234, 0, 3, 1'b1);
    do_pixel(16'h4000, 2, 10, 1'b0);
    do_pixel(16'h2000, TO, 1, 1'b0);

    for (int n = 0; n < 20; n++) begin
      lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
      do_pixel(16'($urandom), lat, int'($urandom_range(0, 4)), 1'(($urandom_range(0, 3) == 0)));
    end

    @(negedge clk);
    recip_done = 1'b0;
    in_valid   = 1'b1;
    in_dark    = 16'h3333;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rw_recip_start", recip_start, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rw_in_ready", in_ready, 0);
    chk("rw_recip_start_low", recip_start, 0);
    chk("rw_recip_abort_low", recip_abort, 0);
    chk("rw_out_valid", out_valid, 0);
    chk("rw_err", err_timeout, 0);
    chk("rw_sub_a", sub_a, 0);
    chk("rw_operand", recip_operand, 0);
    chk("rw_out_inv_t", out_inv_t, 0);
    err_exp  = 1'b0;
    pix_cnt  = 0;
    run_min  = 16'hFFFF;
    tmin_exp = 16'hFFFF;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rw_release_in_ready", in_ready, 1);
    for (int n = 0; n < 6; n++) begin
      do_pixel(16'($urandom), int'($urandom_range(1, 6)), int'($urandom_range(0, 2)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/dehaze_tx_ctrl.md
Name: dehaze_tx_ctrl

Overview:
- Per-pixel sequencer for the transmission stage of the dehazing pipeline.
- Accepts the normalised dark-channel value (min over channels of I/A, Q0.16) and scales it by OMEGA.
- Drives the external combinational transmission subtractor (t = 1 - x, clamped at 0.25) and captures t.
- Runs the shared multi-cycle reciprocal unit through a start/done handshake, then presents t and 1/t to the recovery stage with valid/ready.
- Counts pixels per frame.

Parameters:
- OMEGA, 16'd62259, haze-retention factor in Q0.16 (0.95).
- TIMEOUT, 64, maximum cycles to wait for recip_done before aborting.
- FRAME_PIXELS, 307200, pixels per frame (640x480).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  controller can accept an input.
- in_dark  in  16  normalised dark-channel value, Q0.16.
- sub_a  out  16  operand to transmission subtractor.
- sub_diff  in  16  subtractor result t, Q0.16, combinational from sub_a.
- recip_start  out  1  one-cycle start pulse to reciprocal unit.
- recip_abort  out  1  one-cycle abort pulse on timeout.
- recip_operand  out  16  t sent to reciprocal unit.
- recip_done  in  1  reciprocal result valid, single-cycle pulse.
- recip_result  in  16  1/t, Q2.14.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_t  out  16  transmission, Q0.16.
- out_inv_t  out  16  reciprocal, Q2.14.
- err_timeout  out  1  sticky timeout flag.
- frame_done  out  1  one-cycle pulse on the last pixel of a frame.

Behaviour:
- Reset values: all outputs 0; in_ready 0 during reset and 1 in the first cycle after release; state IDLE; pixel counter 0; timeout counter 0.
- FSM states: IDLE, SUB, START, WAIT, OUT.
- IDLE: in_ready=1. When in_valid, register scaled = (in_dark*OMEGA)[31:16] as a 32-bit unsigned product, then go to SUB.
- sub_a always equals the scaled register, so it is stable from SUB onward.
- SUB: capture t_reg = sub_diff, then go to START.
- START: recip_start=1 for exactly one cycle with recip_operand=t_reg. Clear the timeout counter. Go to WAIT.
- recip_operand holds t_reg outside START as well.
- WAIT: increment the timeout counter each cycle.
  - recip_done: capture inv_reg = recip_result and go to OUT.
  - Counter reaches TIMEOUT-1 without done: inv_reg = 16'hFFFF (saturated 4.0), recip_abort=1 for one cycle, err_timeout set, go to OUT.
  - done and timeout in the same cycle: done wins, no abort, no error.
- recip_done outside WAIT is ignored.
- OUT: out_valid=1, out_t=t_reg, out_inv_t=inv_reg, all held stable until out_ready.
  - On the handshake: go to IDLE and increment the pixel counter.
  - If the counter was FRAME_PIXELS-1: frame_done=1 in the handshake cycle and the counter wraps to 0.
- Latency: minimum 4 cycles from input accept to out_valid, when recip_done arrives the cycle after recip_start. Throughput is one pixel per (4 + reciprocal latency) cycles.
- out_valid must not depend combinationally on out_ready. in_ready=0 in every state except IDLE.
- err_timeout clears only on reset.
- rst_n asserted in any state returns immediately to IDLE and drops recip_start/recip_abort. The reciprocal unit is assumed to be reset by the same rst_n.

Optional Feature:
- Macro: TX_STATS_EN.
- When defined, adds output t_min[15:0], the minimum out_t over the previous completed frame.
  - The running minimum resets to 16'hFFFF and updates on each output handshake.
  - On the frame_done handshake, t_min loads min(running, current out_t) and the running minimum reloads 16'hFFFF.
  - t_min reset value is 16'hFFFF.
- When undefined, the port and its logic are absent and behaviour is otherwise identical.

Test Plan:
- Nominal, zero dark: in_dark=0, subtractor model, reciprocal returns 16'h4000 one cycle after start -> out_valid at cycle 4, out_t=16'hFFFF, out_inv_t=16'h4000, err_timeout=0.
- Clamp, full dark: in_dark=16'hFFFF, OMEGA=62259 -> sub_a=62258, out_t=16384, recip_operand=16384.
- Timeout: TIMEOUT=32, reciprocal never responds -> recip_abort pulses 32 cycles after start, out_inv_t=16'hFFFF, err_timeout=1 and sticky. A late recip_done afterwards is ignored.
- Backpressure: out_ready held low 10 cycles in OUT -> out_valid, out_t, out_inv_t stable, in_ready=0 throughout, exactly one handshake.
- Frame wrap: FRAME_PIXELS=4, 5 pixels -> frame_done pulses only on the 4th output handshake, counter back to 0. With TX_STATS_EN, t_min equals the smallest of the first 4 out_t values.
- Reset in WAIT: deassert rst_n with recip_start already issued -> outputs return to reset values, in_ready=1 after release, next pixel processed normally.
